trap_ctrl: RTL and testbench
============================

# trap_ctrl

Machine-mode trap controller for the RV64 core. It sits beside the instruction decoder and consumes its exception and `mret` indications. On a trap it performs entry (save context, raise privilege, redirect PC to `mtvec`); on `mret` it performs exit (restore privilege, redirect PC to `mepc`). It drives `trap_taken`/`trap_done` back to the decoder, which suppresses decode while either is high. It owns the trap CSRs and serves them on the CSR read/write path.

## Interface
- `RESET_MTVEC`, default 64'h0: `mtvec` value after reset; bits [1:0] are forced to 0.
- `RESET_PRIV`, default 2'b11: `priv_lvl` after reset.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `exc_en` in 1: exception request from the decoder.
- `exc_code` in 4: exception cause code.
- `exc_val` in 64: trap value, written to `mtval`.
- `mret` in 1: `mret` decoded.
- `pc_addr` in 64: PC of the current instruction.
- `we_csr` in 1: CSR write enable from the decoder.
- `r_csr_addr` in 12: CSR address, used for both read and write.
- `w_csr_data` in 64: CSR write value.
- `trap_taken` out 1: high for exactly the trap-entry cycle.
- `trap_done` out 1: high for exactly the trap-exit cycle.
- `pc_redirect` out 1: the fetch stage must load `pc_redirect_target`.
- `pc_redirect_target` out 64: next PC while `pc_redirect` is high.
- `priv_lvl` out 2: current privilege level (00 U, 01 S, 11 M).
- `csr_hit` out 1: `r_csr_addr` is owned by this block (combinational).
- `csr_rdata` out 64: read value for `r_csr_addr` (combinational); 0 when `csr_hit` is 0.

## Operation
- Owned CSRs:
  - `mstatus` 0x300: MIE[3], MPIE[7], MPP[12:11]; all other bits read 0.
  - `mtvec` 0x305: bits [1:0] read 0 (direct mode only).
  - `mepc` 0x341: bits [1:0] read 0.
  - `mcause` 0x342: bits [63] and [3:0] stored; all other bits read 0.
  - `mtval` 0x343: full 64 bits.
- MPP is WARL. A write of 2'b10 stores 2'b00.
- FSM has three states: IDLE, ENTER, EXIT.
- IDLE with `exc_en`=1 → ENTER. Updates at that edge:
  - `mepc` ← {`pc_addr`[63:2],2'b00}
  - `mcause` ← {1'b0,59'b0,`exc_code`}
  - `mtval` ← `exc_val`
  - MPIE ← MIE, MIE ← 0
  - MPP ← `priv_lvl`, `priv_lvl` ← 2'b11
- IDLE with `mret`=1 and `priv_lvl`=11 → EXIT. Updates at that edge:
  - `priv_lvl` ← MPP
  - MIE ← MPIE, MPIE ← 1
  - MPP ← 2'b00
- IDLE with `mret`=1 and `priv_lvl`≠11: treated as an illegal instruction. This is the ENTER path with `exc_code`=2 and `mtval`=0.
- IDLE with `we_csr`=1 and `csr_hit`=1 (and no `exc_en`/`mret`): write `w_csr_data` to the addressed CSR, applying the field masks above. Writes to unowned addresses are ignored.
- ENTER → IDLE unconditionally. `trap_taken`=1, `pc_redirect`=1, `pc_redirect_target`=`mtvec`.
- EXIT → IDLE unconditionally. `trap_done`=1, `pc_redirect`=1, `pc_redirect_target`=`mepc`.
- In ENTER/EXIT, the inputs `exc_en`, `mret` and `we_csr` are ignored.
- Priority in IDLE: `exc_en` > `mret` > `we_csr`. A CSR write coinciding with a trap is dropped.

## Timing
- Reset values:
  - state IDLE
  - `trap_taken`=0, `trap_done`=0, `pc_redirect`=0, `pc_redirect_target`=0
  - `priv_lvl`=`RESET_PRIV`, `mtvec`=`RESET_MTVEC`&~3
  - `mepc`=`mcause`=`mtval`=0, MIE=MPIE=0, MPP=00
- `rst` dominates every other input. Reset asserted during ENTER or EXIT returns to IDLE on the next edge with no redirect.
- Cycle timing for a trap or `mret`:
  - `exc_en`/`mret` sampled at edge N.
  - `trap_taken`/`trap_done` and `pc_redirect` are high for cycle N+1 only.
  - Updated CSRs and `priv_lvl` are visible from cycle N+1.
- `trap_taken`, `trap_done` and `pc_redirect` are decoded from the registered state. `pc_redirect_target` is combinational from state and CSRs.
- `csr_rdata`/`csr_hit`: zero-latency combinational read. A write at edge N is visible in cycle N+1.
- Minimum spacing is 2 cycles between back-to-back traps. A new `exc_en` is accepted in the cycle after ENTER.

## Test plan
- Reset, then read 0x305 with `RESET_MTVEC`=64'h8000_0103 → `csr_rdata`=64'h8000_0100, `priv_lvl`=11, all redirect/trap outputs 0.
- `priv_lvl`=00, MIE=1, `pc_addr`=64'h1004, `exc_en`=1, `exc_code`=8 → next cycle:
  - `trap_taken`=1, `pc_redirect_target`=`mtvec`
  - `mepc`=64'h1004, `mcause`=8, MPP=00, MPIE=1, MIE=0, `priv_lvl`=11
  - following cycle all pulses 0.
- After the previous scenario, `mret` → next cycle:
  - `trap_done`=1, `pc_redirect_target`=64'h1004
  - `priv_lvl`=00, MIE=1, MPIE=1, MPP=00.
- `mret` at `priv_lvl`=01 → ENTER with `mcause`=2, `mtval`=0, MPP=01.
- CSR writes:
  - `mstatus` ← 64'hFFFF_FFFF_FFFF_FFFF → reads 64'h1888.
  - `mstatus` ← 64'h1000 (MPP=10) → MPP reads 00.
  - `mepc` ← 64'h2003 → reads 64'h2000.
- `exc_en` and `we_csr` (0x341, 64'h5000) in the same cycle → `mepc` holds `pc_addr`, not 64'h5000. `rst` asserted during ENTER → IDLE next cycle, `pc_redirect`=0, all CSRs at reset values.

Source files
------------

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap entry/exit controller and trap CSR file
module trap_ctrl #(
    parameter logic [63:0] RESET_MTVEC = 64'h0,
    parameter logic [1:0]  RESET_PRIV  = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_en,
    input  logic [3:0]  exc_code,
    input  logic [63:0] exc_val,
    input  logic        mret,
    input  logic [63:0] pc_addr,
    input  logic        we_csr,
    input  logic [11:0] r_csr_addr,
    input  logic [63:0] w_csr_data,
    output logic        trap_taken,
    output logic        trap_done,
    output logic        pc_redirect,
    output logic [63:0] pc_redirect_target,
    output logic [1:0]  priv_lvl,
    output logic        csr_hit,
    output logic [63:0] csr_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ENTER = 2'd1;
    localparam logic [1:0] S_EXIT  = 2'd2;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    logic [1:0]  state;
    logic        mie;
    logic        mpie;
    logic [1:0]  mpp;
    logic [61:0] mtvec_q;
    logic [61:0] mepc_q;
    logic        mcause_int;
    logic [3:0]  mcause_code;
    logic [63:0] mtval_q;
    logic [1:0]  priv_q;

    // mret outside M-mode is an illegal instruction and enters the trap path
    logic        illegal_mret;
    logic        trap_req;
    logic        mret_ok;
    logic [3:0]  trap_code;
    logic [63:0] trap_val;
    logic [1:0]  wr_mpp;

    always_comb begin
        illegal_mret = mret && (priv_q != 2'b11);
        trap_req     = exc_en || illegal_mret;
        mret_ok      = !exc_en && mret && (priv_q == 2'b11);
        trap_code    = exc_en ? exc_code : 4'd2;
        trap_val     = exc_en ? exc_val : 64'h0;
        wr_mpp       = (w_csr_data[12:11] == 2'b10) ? 2'b00 : w_csr_data[12:11];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            mie         <= 1'b0;
            mpie        <= 1'b0;
            mpp         <= 2'b00;
            mtvec_q     <= RESET_MTVEC[63:2];
            mepc_q      <= '0;
            mcause_int  <= 1'b0;
            mcause_code <= 4'd0;
            mtval_q     <= '0;
            priv_q      <= RESET_PRIV;
        end else if (state == S_IDLE) begin
            if (trap_req) begin
                state       <= S_ENTER;
                mepc_q      <= pc_addr[63:2];
                mcause_int  <= 1'b0;
                mcause_code <= trap_code;
                mtval_q     <= trap_val;
                mpie        <= mie;
                mie         <= 1'b0;
                mpp         <= priv_q;
                priv_q      <= 2'b11;
            end else if (mret_ok) begin
                state  <= S_EXIT;
                priv_q <= mpp;
                mie    <= mpie;
                mpie   <= 1'b1;
                mpp    <= 2'b00;
            end else if (we_csr) begin
                case (r_csr_addr)
                    A_MSTATUS: begin
                        mie  <= w_csr_data[3];
                        mpie <= w_csr_data[7];
                        mpp  <= wr_mpp;
                    end
                    A_MTVEC:  mtvec_q <= w_csr_data[63:2];
                    A_MEPC:   mepc_q  <= w_csr_data[63:2];
                    A_MCAUSE: begin
                        mcause_int  <= w_csr_data[63];
                        mcause_code <= w_csr_data[3:0];
                    end
                    A_MTVAL:  mtval_q <= w_csr_data;
                    default: ;
                endcase
            end
        end else begin
            state <= S_IDLE;
        end
    end

    always_comb begin
        trap_taken         = (state == S_ENTER);
        trap_done          = (state == S_EXIT);
        pc_redirect        = trap_taken || trap_done;
        priv_lvl           = priv_q;
        pc_redirect_target = 64'h0;
        if (state == S_ENTER)
            pc_redirect_target = {mtvec_q, 2'b00};
        else if (state == S_EXIT)
            pc_redirect_target = {mepc_q, 2'b00};
    end

    always_comb begin
        csr_hit   = 1'b1;
        csr_rdata = 64'h0;
        case (r_csr_addr)
            A_MSTATUS: csr_rdata = {51'h0, mpp, 3'b000, mpie, 3'b000, mie, 3'b000};
            A_MTVEC:   csr_rdata = {mtvec_q, 2'b00};
            A_MEPC:    csr_rdata = {mepc_q, 2'b00};
            A_MCAUSE:  csr_rdata = {mcause_int, 59'h0, mcause_code};
            A_MTVAL:   csr_rdata = mtval_q;
            default:   csr_hit   = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - scoreboard bench for trap_ctrl with directed vectors
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;
    logic        mret;
    logic [63:0] pc_addr;
    logic        we_csr;
    logic [11:0] r_csr_addr;
    logic [63:0] w_csr_data;
    logic        trap_taken;
    logic        trap_done;
    logic        pc_redirect;
    logic [63:0] pc_redirect_target;
    logic [1:0]  priv_lvl;
    logic        csr_hit;
    logic [63:0] csr_rdata;

    trap_ctrl #(.RESET_MTVEC(64'h8000_0103), .RESET_PRIV(2'b11)) dut (
        .clk(clk), .rst(rst), .exc_en(exc_en), .exc_code(exc_code), .exc_val(exc_val),
        .mret(mret), .pc_addr(pc_addr), .we_csr(we_csr), .r_csr_addr(r_csr_addr),
        .w_csr_data(w_csr_data), .trap_taken(trap_taken), .trap_done(trap_done),
        .pc_redirect(pc_redirect), .pc_redirect_target(pc_redirect_target),
        .priv_lvl(priv_lvl), .csr_hit(csr_hit), .csr_rdata(csr_rdata)
    );

    always #5 clk = ~clk;

    localparam int SEL_RDATA = 0, SEL_TAKEN = 1, SEL_DONE = 2, SEL_REDIR = 3,
                   SEL_TGT = 4, SEL_PRIV = 5, SEL_HIT = 6;

    typedef struct {
        int          cyc;
        int          sel;
        logic [63:0] exp;
        string       name;
    } item_t;

    item_t q[$];
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] observe(int sel);
        case (sel)
            SEL_RDATA: return csr_rdata;
            SEL_TAKEN: return {63'h0, trap_taken};
            SEL_DONE:  return {63'h0, trap_done};
            SEL_REDIR: return {63'h0, pc_redirect};
            SEL_TGT:   return pc_redirect_target;
            SEL_PRIV:  return {62'h0, priv_lvl};
            default:   return {63'h0, csr_hit};
        endcase
    endfunction

    // Monitor: compares every expectation scheduled for the current cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            item_t it;
            logic [63:0] act;
            it = q.pop_front();
            checks++;
            act = observe(it.sel);
            if (it.cyc != cyc) begin
                failures++;
                $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", it.name, it.cyc, cyc);
            end else if (act !== it.exp) begin
                failures++;
                $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
            end
        end
    end

    task automatic expect_now(int sel, logic [63:0] v, string nm);
        item_t it;
        it.cyc = cyc; it.sel = sel; it.exp = v; it.name = nm;
        q.push_back(it);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        exc_en = 1'b0; mret = 1'b0; we_csr = 1'b0;
    endtask

    task automatic rd(logic [11:0] a, logic [63:0] v, string nm);
        r_csr_addr = a;
        expect_now(SEL_RDATA, v, nm);
    endtask

    task automatic pulses(logic tk, logic dn, logic [63:0] tgt, string nm);
        expect_now(SEL_TAKEN, {63'h0, tk}, {nm, "_taken"});
        expect_now(SEL_DONE, {63'h0, dn}, {nm, "_done"});
        expect_now(SEL_REDIR, {63'h0, tk | dn}, {nm, "_redirect"});
        expect_now(SEL_TGT, tgt, {nm, "_target"});
    endtask

    task automatic wr(logic [11:0] a, logic [63:0] d);
        idle_in(); we_csr = 1'b1; r_csr_addr = a; w_csr_data = d;
        step();
        idle_in();
    endtask

    task automatic trap(logic [3:0] code, logic [63:0] pc, logic [63:0] val);
        idle_in(); exc_en = 1'b1; exc_code = code; pc_addr = pc; exc_val = val;
        step();
        idle_in();
    endtask

    initial begin
        rst = 1'b1; idle_in(); exc_code = 4'd0; exc_val = 64'h0; pc_addr = 64'h0;
        r_csr_addr = 12'h305; w_csr_data = 64'h0;
        step(); step();
        rst = 1'b0;
        rd(12'h305, 64'h8000_0100, "reset_mtvec");
        expect_now(SEL_PRIV, 64'd3, "reset_priv");
        pulses(1'b0, 1'b0, 64'h0, "reset");
        step();
        rd(12'h300, 64'h0, "reset_mstatus"); step();
        rd(12'h123, 64'h0, "unowned_rdata");
        expect_now(SEL_HIT, 64'h0, "unowned_hit"); step();

        // drop to U-mode with MIE=1 via mret using MPIE=1, MPP=00
        wr(12'h300, 64'h80);
        mret = 1'b1; step(); idle_in();
        pulses(1'b0, 1'b1, 64'h0, "setup_exit");
        expect_now(SEL_PRIV, 64'd0, "setup_priv");
        rd(12'h300, 64'h88, "setup_mstatus"); step();

        trap(4'd8, 64'h1004, 64'hDEAD);
        pulses(1'b1, 1'b0, 64'h8000_0100, "enter");
        expect_now(SEL_PRIV, 64'd3, "enter_priv");
        rd(12'h341, 64'h1004, "enter_mepc"); step();
        pulses(1'b0, 1'b0, 64'h0, "after_enter");
        rd(12'h342, 64'h8, "enter_mcause"); step();
        rd(12'h300, 64'h80, "enter_mstatus"); step();
        rd(12'h343, 64'hDEAD, "enter_mtval"); step();

        mret = 1'b1; step(); idle_in();
        pulses(1'b0, 1'b1, 64'h1004, "exit");
        expect_now(SEL_PRIV, 64'd0, "exit_priv");
        rd(12'h300, 64'h88, "exit_mstatus"); step();
        pulses(1'b0, 1'b0, 64'h0, "after_exit"); step();

        // reach S-mode, then mret there is illegal
        trap(4'd3, 64'h3000, 64'h0); step();
        wr(12'h300, 64'h800);
        mret = 1'b1; step(); idle_in();
        expect_now(SEL_PRIV, 64'd1, "smode_priv"); step();
        mret = 1'b1; pc_addr = 64'h2008; step(); idle_in();
        pulses(1'b1, 1'b0, 64'h8000_0100, "illegal_mret");
        expect_now(SEL_PRIV, 64'd3, "illegal_priv");
        rd(12'h342, 64'h2, "illegal_mcause"); step();
        rd(12'h343, 64'h0, "illegal_mtval"); step();
        rd(12'h300, 64'h800, "illegal_mstatus"); step();
        rd(12'h341, 64'h2008, "illegal_mepc"); step();

        wr(12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(12'h300, 64'h1888, "mstatus_ones"); step();
        wr(12'h300, 64'h1000);
        rd(12'h300, 64'h0, "mpp_warl"); step();
        wr(12'h341, 64'h2003);
        rd(12'h341, 64'h2000, "mepc_align"); step();
        wr(12'h342, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(12'h342, 64'h8000_0000_0000_000F, "mcause_mask"); step();
        wr(12'h305, 64'h4000_0007);
        rd(12'h305, 64'h4000_0004, "mtvec_align"); step();
        wr(12'h343, 64'h1234_5678_9ABC_DEF0);
        rd(12'h343, 64'h1234_5678_9ABC_DEF0, "mtval_full"); step();

        // trap and CSR write in the same cycle: the write is dropped
        idle_in(); exc_en = 1'b1; exc_code = 4'd5; pc_addr = 64'h7000;
        we_csr = 1'b1; r_csr_addr = 12'h341; w_csr_data = 64'h5000;
        step(); idle_in();
        rd(12'h341, 64'h7000, "coincident_mepc"); step();

        // exc_en held: ENTER ignores it, the following IDLE accepts it
        exc_en = 1'b1; exc_code = 4'd1; pc_addr = 64'h9000; step();
        expect_now(SEL_TAKEN, 64'd1, "b2b_first"); step();
        expect_now(SEL_TAKEN, 64'd0, "b2b_gap"); step();
        idle_in();
        expect_now(SEL_TAKEN, 64'd1, "b2b_second"); step();

        trap(4'd4, 64'hA000, 64'h55);
        expect_now(SEL_TAKEN, 64'd1, "rst_enter_taken");
        rst = 1'b1; step(); rst = 1'b0;
        pulses(1'b0, 1'b0, 64'h0, "rst_in_enter");
        expect_now(SEL_PRIV, 64'd3, "rst_priv");
        rd(12'h341, 64'h0, "rst_mepc"); step();
        rd(12'h305, 64'h8000_0100, "rst_mtvec"); step();
        rd(12'h342, 64'h0, "rst_mcause"); step();
        rd(12'h343, 64'h0, "rst_mtval"); step();
        rd(12'h300, 64'h0, "rst_mstatus"); step();

        step(); step();
        if (q.size() != 0) begin
            failures += q.size();
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
